// File: rtl/udm_bus_arbiter.sv
// Round-robin arbiter sharing one req/ack/resp slave bus between several masters.
// Outstanding reads are tracked in an in-order ID FIFO so responses return to their issuer.
module udm_bus_arbiter #(
    parameter int N_MASTERS   = 2,
    parameter int OUTST_DEPTH = 4,
    localparam int ID_W  = (N_MASTERS > 2) ? $clog2(N_MASTERS) : 1,
    localparam int CNT_W = $clog2(OUTST_DEPTH + 1),
    localparam int PTR_W = (OUTST_DEPTH > 1) ? $clog2(OUTST_DEPTH) : 1
) (
    input  logic                    clk_i,
    input  logic                    arst_n_i,
    input  logic [N_MASTERS-1:0]    m_req_i,
    input  logic [N_MASTERS-1:0]    m_we_i,
    input  logic [N_MASTERS*32-1:0] m_addr_bi,
    input  logic [N_MASTERS*4-1:0]  m_be_bi,
    input  logic [N_MASTERS*32-1:0] m_wdata_bi,
    output logic [N_MASTERS-1:0]    m_ack_o,
    output logic [N_MASTERS-1:0]    m_resp_o,
    output logic [N_MASTERS*32-1:0] m_rdata_bo,
    output logic                    s_req_o,
    output logic                    s_we_o,
    output logic [31:0]             s_addr_bo,
    output logic [3:0]              s_be_bo,
    output logic [31:0]             s_wdata_bo,
    input  logic                    s_ack_i,
    input  logic                    s_resp_i,
    input  logic [31:0]             s_rdata_bi,
    output logic                    err_o
);

    logic [ID_W-1:0]  rr_ptr;
    logic [ID_W-1:0]  grant;
    logic             any_req;
    logic [ID_W:0]    scan_idx;
    logic             blocked;
    logic             accept;
    logic             push;
    logic             pop;
    logic [ID_W-1:0]  head_id;

    logic [ID_W-1:0]  id_mem [OUTST_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] cnt;

    // Scan requesters starting at rr_ptr; the first hit wins.
    always_comb begin
        grant    = '0;
        any_req  = 1'b0;
        scan_idx = '0;
        for (int i = 0; i < N_MASTERS; i++) begin
            scan_idx = {1'b0, rr_ptr} + (ID_W+1)'(i);
            if (scan_idx >= (ID_W+1)'(N_MASTERS)) begin
                scan_idx = scan_idx - (ID_W+1)'(N_MASTERS);
            end
            if (!any_req && m_req_i[scan_idx[ID_W-1:0]]) begin
                any_req = 1'b1;
                grant   = scan_idx[ID_W-1:0];
            end
        end
    end

    // A blocked read stalls the bus rather than skipping ahead, keeping rotation fair.
    assign blocked = !m_we_i[grant] && (cnt == CNT_W'(OUTST_DEPTH));
    assign s_req_o = arst_n_i && any_req && !blocked;
    assign accept  = s_req_o && s_ack_i;
    assign push    = accept && !m_we_i[grant];
    assign pop     = s_resp_i && (cnt != '0);
    assign head_id = id_mem[rd_ptr];

    assign s_we_o     = m_we_i[grant];
    assign s_addr_bo  = m_addr_bi[32*grant +: 32];
    assign s_be_bo    = m_be_bi[4*grant +: 4];
    assign s_wdata_bo = m_wdata_bi[32*grant +: 32];

    always_comb begin
        m_ack_o        = '0;
        m_ack_o[grant] = accept;
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            id_mem[wr_ptr] <= grant;
        end
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            rr_ptr     <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            cnt        <= '0;
            m_resp_o   <= '0;
            m_rdata_bo <= '0;
            err_o      <= 1'b0;
        end else begin
            if (accept) begin
                rr_ptr <= (grant == ID_W'(N_MASTERS - 1)) ? '0 : grant + 1'b1;
            end
            if (push) begin
                wr_ptr <= (wr_ptr == PTR_W'(OUTST_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PTR_W'(OUTST_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase

            m_resp_o   <= '0;
            m_rdata_bo <= '0;
            if (pop) begin
                m_resp_o[head_id]            <= 1'b1;
                m_rdata_bo[32*head_id +: 32] <= s_rdata_bi;
            end
            err_o <= s_resp_i && (cnt == '0);
        end
    end

endmodule

// File: tb/tb_udm_bus_arbiter.sv
// Directed bench for udm_bus_arbiter: fairness, read routing, FIFO full blocking,
// response ordering and spurious-response error reporting.
module tb_udm_bus_arbiter;

    logic        clk_i;
    logic        arst_n_i;
    logic [1:0]  m_req_i;
    logic [1:0]  m_we_i;
    logic [63:0] m_addr_bi;
    logic [7:0]  m_be_bi;
    logic [63:0] m_wdata_bi;
    logic [1:0]  m_ack_o;
    logic [1:0]  m_resp_o;
    logic [63:0] m_rdata_bo;
    logic        s_req_o;
    logic        s_we_o;
    logic [31:0] s_addr_bo;
    logic [3:0]  s_be_bo;
    logic [31:0] s_wdata_bo;
    logic        s_ack_i;
    logic        s_resp_i;
    logic [31:0] s_rdata_bi;
    logic        err_o;

    int testCount = 0;
    int failCount = 0;

    udm_bus_arbiter #(.N_MASTERS(2), .OUTST_DEPTH(4)) dut (
        .clk_i(clk_i), .arst_n_i(arst_n_i),
        .m_req_i(m_req_i), .m_we_i(m_we_i), .m_addr_bi(m_addr_bi),
        .m_be_bi(m_be_bi), .m_wdata_bi(m_wdata_bi),
        .m_ack_o(m_ack_o), .m_resp_o(m_resp_o), .m_rdata_bo(m_rdata_bo),
        .s_req_o(s_req_o), .s_we_o(s_we_o), .s_addr_bo(s_addr_bo),
        .s_be_bo(s_be_bo), .s_wdata_bo(s_wdata_bo),
        .s_ack_i(s_ack_i), .s_resp_i(s_resp_i), .s_rdata_bi(s_rdata_bi),
        .err_o(err_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        testCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Advance one clock and land just after the edge so registered outputs are settled.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic applyStimulus(input int k, input logic req, input logic we,
                                 input logic [31:0] addr, input logic [31:0] wdata);
        m_req_i[k]             = req;
        m_we_i[k]              = we;
        m_addr_bi[32*k +: 32]  = addr;
        m_wdata_bi[32*k +: 32] = wdata;
        m_be_bi[4*k +: 4]      = 4'hF;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        arst_n_i   = 1'b0;
        m_req_i    = '0;
        m_we_i     = '0;
        m_addr_bi  = '0;
        m_be_bi    = '0;
        m_wdata_bi = '0;
        s_ack_i    = 1'b0;
        s_resp_i   = 1'b0;
        s_rdata_bi = '0;

        // Reset with both masters requesting
        applyStimulus(0, 1'b1, 1'b1, 32'h0, 32'h0);
        applyStimulus(1, 1'b1, 1'b1, 32'h4, 32'h0);
        s_ack_i = 1'b1;
        tick();
        tick();
        checkOutput("rst_s_req", {63'd0, s_req_o}, 64'd0);
        checkOutput("rst_ack", {62'd0, m_ack_o}, 64'd0);
        checkOutput("rst_resp", {62'd0, m_resp_o}, 64'd0);
        checkOutput("rst_rdata", m_rdata_bo, 64'd0);
        checkOutput("rst_err", {63'd0, err_o}, 64'd0);
        arst_n_i = 1'b1;
        settle();

        // Fairness: alternating write grants 0,1,0,1,0,1
        for (int c = 0; c < 6; c++) begin
            checkOutput($sformatf("rr_ack_%0d", c), {62'd0, m_ack_o}, (c % 2 == 0) ? 64'd1 : 64'd2);
            checkOutput($sformatf("rr_addr_%0d", c), {32'd0, s_addr_bo}, (c % 2 == 0) ? 64'h0 : 64'h4);
            checkOutput($sformatf("rr_we_%0d", c), {63'd0, s_we_o}, 64'd1);
            tick();
        end
        applyStimulus(0, 1'b0, 1'b0, 32'h0, 32'h0);
        applyStimulus(1, 1'b0, 1'b0, 32'h0, 32'h0);

        // Read routing: M1 reads 0x4, response two cycles later
        applyStimulus(1, 1'b1, 1'b0, 32'h4, 32'h0);
        settle();
        checkOutput("rd_ack", {62'd0, m_ack_o}, 64'd2);
        checkOutput("rd_we", {63'd0, s_we_o}, 64'd0);
        checkOutput("rd_addr", {32'd0, s_addr_bo}, 64'h4);
        tick();
        applyStimulus(1, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        s_resp_i   = 1'b1;
        s_rdata_bi = 32'h0000A5A5;
        tick();
        s_resp_i = 1'b0;
        checkOutput("rd_resp", {62'd0, m_resp_o}, 64'd2);
        checkOutput("rd_rdata", m_rdata_bo, 64'h0000A5A5_00000000);
        checkOutput("rd_err", {63'd0, err_o}, 64'd0);
        tick();
        checkOutput("rd_resp_clr", {62'd0, m_resp_o}, 64'd0);
        checkOutput("rd_rdata_clr", m_rdata_bo, 64'd0);

        // Full FIFO: four M0 reads fill it, the fifth stalls
        applyStimulus(0, 1'b1, 1'b0, 32'h10, 32'h0);
        for (int i = 0; i < 4; i++) begin
            settle();
            checkOutput($sformatf("fill_ack_%0d", i), {62'd0, m_ack_o}, 64'd1);
            tick();
        end
        settle();
        checkOutput("full_s_req", {63'd0, s_req_o}, 64'd0);
        checkOutput("full_ack", {62'd0, m_ack_o}, 64'd0);
        applyStimulus(1, 1'b1, 1'b1, 32'h8, 32'hDEAD);
        settle();
        checkOutput("full_wr_ack", {62'd0, m_ack_o}, 64'd2);
        checkOutput("full_wr_addr", {32'd0, s_addr_bo}, 64'h8);
        tick();
        applyStimulus(1, 1'b0, 1'b0, 32'h0, 32'h0);
        s_resp_i   = 1'b1;
        s_rdata_bi = 32'h11;
        settle();
        checkOutput("full_pop_block", {63'd0, s_req_o}, 64'd0);
        tick();
        s_resp_i = 1'b0;
        settle();
        checkOutput("full_pop_resp", {62'd0, m_resp_o}, 64'd1);
        checkOutput("full_pop_rdata", m_rdata_bo, 64'h11);
        checkOutput("full_unblock_ack", {62'd0, m_ack_o}, 64'd1);
        tick();
        applyStimulus(0, 1'b0, 1'b0, 32'h0, 32'h0);
        for (int i = 0; i < 4; i++) begin
            s_resp_i   = 1'b1;
            s_rdata_bi = 32'h20 + 32'(i);
            tick();
            checkOutput($sformatf("drain_resp_%0d", i), {62'd0, m_resp_o}, 64'd1);
            checkOutput($sformatf("drain_rdata_%0d", i), m_rdata_bo, 64'h20 + 64'(i));
        end
        s_resp_i = 1'b0;
        tick();
        checkOutput("drain_idle", {62'd0, m_resp_o}, 64'd0);
        checkOutput("drain_err", {63'd0, err_o}, 64'd0);

        // Ordering: reads M0, M1, M0; the third push overlaps the first pop
        applyStimulus(0, 1'b1, 1'b0, 32'h100, 32'h0);
        settle();
        checkOutput("ord_ack0", {62'd0, m_ack_o}, 64'd1);
        tick();
        applyStimulus(0, 1'b0, 1'b0, 32'h0, 32'h0);
        applyStimulus(1, 1'b1, 1'b0, 32'h104, 32'h0);
        settle();
        checkOutput("ord_ack1", {62'd0, m_ack_o}, 64'd2);
        tick();
        applyStimulus(1, 1'b0, 1'b0, 32'h0, 32'h0);
        applyStimulus(0, 1'b1, 1'b0, 32'h108, 32'h0);
        s_resp_i   = 1'b1;
        s_rdata_bi = 32'h1;
        settle();
        checkOutput("ord_ack2", {62'd0, m_ack_o}, 64'd1);
        tick();
        applyStimulus(0, 1'b0, 1'b0, 32'h0, 32'h0);
        s_rdata_bi = 32'h2;
        settle();
        checkOutput("ord_resp1", {62'd0, m_resp_o}, 64'd1);
        checkOutput("ord_rdata1", m_rdata_bo, 64'h1);
        tick();
        s_rdata_bi = 32'h3;
        checkOutput("ord_resp2", {62'd0, m_resp_o}, 64'd2);
        checkOutput("ord_rdata2", m_rdata_bo, 64'h00000002_00000000);
        tick();
        s_resp_i = 1'b0;
        checkOutput("ord_resp3", {62'd0, m_resp_o}, 64'd1);
        checkOutput("ord_rdata3", m_rdata_bo, 64'h3);
        checkOutput("ord_err", {63'd0, err_o}, 64'd0);
        tick();
        checkOutput("ord_idle", {62'd0, m_resp_o}, 64'd0);

        // Spurious response with nothing outstanding
        s_resp_i   = 1'b1;
        s_rdata_bi = 32'hBAD;
        tick();
        s_resp_i = 1'b0;
        checkOutput("spur_err", {63'd0, err_o}, 64'd1);
        checkOutput("spur_resp", {62'd0, m_resp_o}, 64'd0);
        tick();
        checkOutput("spur_err_clr", {63'd0, err_o}, 64'd0);

        // Reset drops outstanding reads; a late response becomes an error
        applyStimulus(1, 1'b1, 1'b0, 32'h200, 32'h0);
        tick();
        applyStimulus(1, 1'b0, 1'b0, 32'h0, 32'h0);
        arst_n_i = 1'b0;
        #2;
        arst_n_i = 1'b1;
        tick();
        s_resp_i = 1'b1;
        tick();
        s_resp_i = 1'b0;
        checkOutput("midrst_err", {63'd0, err_o}, 64'd1);
        checkOutput("midrst_resp", {62'd0, m_resp_o}, 64'd0);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
